// File: rtl/xadc_multi_pwm.sv
// Round-robin XADC DRP reader feeding an N-channel PWM bank.
// Duties update at period wrap so each PWM period is glitch-free.
module xadc_multi_pwm #(
    parameter int unsigned         N_CH       = 4,
    parameter logic [N_CH*7-1:0]   CH_ADDRS   = {7'h1c, 7'h14, 7'h13, 7'h03},
    parameter int unsigned         MASK_LSB   = 4,
    parameter int unsigned         PWM_MAX    = 4070,
    parameter bit                  ACTIVE_LOW = 1'b1,
    parameter int unsigned         TIMEOUT    = 63
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            eoc_in,
    input  logic            drdy_in,
    input  logic [15:0]     do_in,
    output logic [6:0]      daddr_out,
    output logic            den_out,
    output logic            dwe_out,
    input  logic [2:0]      sel,
    output logic [3:0]      data_out,
    output logic [N_CH-1:0] pwm_out,
    output logic            sample_vld,
    output logic            timeout_err
);

    localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned CW = ($clog2(PWM_MAX + 1) > 12) ? $clog2(PWM_MAX + 1) : 12;
    localparam logic [11:0] KEEP_MASK = 12'(~((1 << MASK_LSB) - 1));

    typedef enum logic [1:0] {StIdle, StReq, StWait, StStore} state_e;

    state_e          state_q;
    logic [IW-1:0]   ch_idx_q;
    logic [IW-1:0]   next_ch;
    logic [TW-1:0]   tmo_q;
    logic [6:0]      cur_addr;
    logic [11:0]     masked_sample;
    logic [11:0]     duty_q     [N_CH];
    logic [11:0]     act_duty_q [N_CH];
    logic [CW-1:0]   cnt_q;
    logic [N_CH-1:0] raw_q;

    assign dwe_out       = 1'b0;
    assign masked_sample = 12'(do_in >> 4) & KEEP_MASK;
    assign next_ch       = (ch_idx_q == IW'(N_CH - 1)) ? '0 : ch_idx_q + 1'b1;

    always_comb begin
        cur_addr = CH_ADDRS[6:0];
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx_q == IW'(i)) cur_addr = CH_ADDRS[i*7 +: 7];
        end
    end

    // Shows the pending duty, not the one the PWM is currently using.
    always_comb begin
        data_out = 4'h0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == 3'(i)) data_out = duty_q[i][11:8];
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ch_idx_q    <= '0;
            tmo_q       <= '0;
            daddr_out   <= CH_ADDRS[6:0];
            den_out     <= 1'b0;
            sample_vld  <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < N_CH; i++) duty_q[i] <= '0;
        end else begin
            den_out    <= 1'b0;
            sample_vld <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (eoc_in) begin
                        state_q   <= StReq;
                        den_out   <= 1'b1;
                        daddr_out <= cur_addr;
                        tmo_q     <= '0;
                    end
                end
                StReq: state_q <= StWait;
                StWait: begin
                    if (drdy_in) begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (ch_idx_q == IW'(i)) duty_q[i] <= masked_sample;
                        end
                        sample_vld <= 1'b1;
                        state_q    <= StStore;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        // Abandon the read; skip to the next channel so one dead input
                        // cannot stall the whole scan.
                        timeout_err <= 1'b1;
                        ch_idx_q    <= next_ch;
                        state_q     <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StStore: begin
                    ch_idx_q <= next_ch;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            raw_q <= '0;
            for (int i = 0; i < N_CH; i++) act_duty_q[i] <= '0;
        end else begin
            if (cnt_q == CW'(PWM_MAX)) begin
                cnt_q <= '0;
                for (int i = 0; i < N_CH; i++) act_duty_q[i] <= duty_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            for (int i = 0; i < N_CH; i++) raw_q[i] <= (cnt_q < CW'(act_duty_q[i]));
        end
    end

    assign pwm_out = raw_q ^ {N_CH{ACTIVE_LOW}};

endmodule

// File: tb/tb_xadc_multi_pwm.sv
// Self-checking bench for xadc_multi_pwm: random DRP data against a channel/duty model,
// PWM timing measured in cycles against the period arithmetic.
module tb_xadc_multi_pwm;

    localparam int N_CH    = 4;
    localparam int PWM_MAX = 4070;
    localparam int PERIOD  = PWM_MAX + 1;
    localparam int TIMEOUT = 63;

    logic            sysclk = 1'b0;
    logic            rst = 1'b1;
    logic            eoc_in = 1'b0;
    logic            drdy_in = 1'b0;
    logic [15:0]     do_in = 16'h0;
    logic [2:0]      sel = 3'd0;
    logic [6:0]      daddr_out;
    logic            den_out;
    logic            dwe_out;
    logic [3:0]      data_out;
    logic [N_CH-1:0] pwm_out;
    logic            sample_vld;
    logic            timeout_err;

    xadc_multi_pwm #(
        .N_CH      (N_CH),
        .CH_ADDRS  ({7'h1c, 7'h14, 7'h13, 7'h03}),
        .MASK_LSB  (4),
        .PWM_MAX   (PWM_MAX),
        .ACTIVE_LOW(1'b1),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .eoc_in     (eoc_in),
        .drdy_in    (drdy_in),
        .do_in      (do_in),
        .daddr_out  (daddr_out),
        .den_out    (den_out),
        .dwe_out    (dwe_out),
        .sel        (sel),
        .data_out   (data_out),
        .pwm_out    (pwm_out),
        .sample_vld (sample_vld),
        .timeout_err(timeout_err)
    );

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;
    int den_cnt = 0;
    int vld_cnt = 0;
    int cyc = 0;

    always @(posedge sysclk) cyc++;
    always @(negedge sysclk) begin
        if (!rst) begin
            if (den_out) den_cnt++;
            if (sample_vld) vld_cnt++;
        end
    end

    // Reference model: address table, stored duties, next channel to read.
    logic [6:0]  addr_tbl [N_CH] = '{7'h03, 7'h13, 7'h14, 7'h1c};
    logic [11:0] exp_duty [N_CH];
    int          exp_ch;

    function automatic logic [11:0] masked(input logic [15:0] d);
        int v;
        v = int'(d) / 16;
        v = (v / 16) * 16;
        return 12'(v);
    endfunction

    task automatic model_reset();
        exp_ch = 0;
        for (int i = 0; i < N_CH; i++) exp_duty[i] = 12'h0;
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] data, input int dly, output logic den_seen,
                           output logic [6:0] addr, output logic vld_seen);
        eoc_in = 1'b1;
        tick();
        eoc_in   = 1'b0;
        den_seen = den_out;
        addr     = daddr_out;
        repeat (dly) tick();
        drdy_in = 1'b1;
        do_in   = data;
        tick();
        drdy_in  = 1'b0;
        do_in    = 16'($urandom);
        vld_seen = sample_vld;
        tick();
        exp_duty[exp_ch] = masked(data);
        exp_ch = (exp_ch + 1) % N_CH;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if (den_out !== 1'b0) begin
            errors++; $display("FAIL reset_den: got %0b want 0", den_out);
        end
        checks++;
        if (pwm_out !== 4'hF) begin
            errors++; $display("FAIL reset_pwm: got %0h want f", pwm_out);
        end
        checks++;
        if (daddr_out !== 7'h03) begin
            errors++; $display("FAIL reset_daddr: got %0h want 03", daddr_out);
        end
        checks++;
        if ({sample_vld, timeout_err, dwe_out} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %0b want 000", {sample_vld, timeout_err, dwe_out});
        end
        checks++;
        if (data_out !== 4'h0) begin
            errors++; $display("FAIL reset_data: got %0h want 0", data_out);
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_round_robin();
        int d0 = den_cnt;
        int v0 = vld_cnt;
        logic den_s, vld_s;
        logic [6:0] addr_s, want;
        for (int k = 0; k < 5; k++) begin
            want = addr_tbl[exp_ch];
            do_read(16'($urandom), 3, den_s, addr_s, vld_s);
            checks++;
            if (addr_s !== want || den_s !== 1'b1 || vld_s !== 1'b1) begin
                errors++;
                $display("FAIL rr_read%0d: got addr=%0h den=%0b vld=%0b want addr=%0h den=1 vld=1",
                         k, addr_s, den_s, vld_s, want);
            end
        end
        checks++;
        if (den_cnt - d0 != 5 || vld_cnt - v0 != 5) begin
            errors++;
            $display("FAIL rr_counts: got den=%0d vld=%0d want 5 5", den_cnt - d0, vld_cnt - v0);
        end
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #0.5;
            checks++;
            if (data_out !== ((s < N_CH) ? exp_duty[s][11:8] : 4'h0)) begin
                errors++;
                $display("FAIL rr_data_sel%0d: got %0h want %0h", s, data_out,
                         (s < N_CH) ? exp_duty[s][11:8] : 4'h0);
            end
        end
    endtask

    task automatic test_masking();
        logic den_s, vld_s;
        logic [6:0] addr_s;
        while (exp_ch != 1) do_read(16'($urandom), $urandom_range(1, 8), den_s, addr_s, vld_s);
        do_read(16'hFFFF, $urandom_range(1, 8), den_s, addr_s, vld_s);
        sel = 3'd1;
        #0.5;
        checks++;
        if (data_out !== 4'hF) begin
            errors++; $display("FAIL mask_ffff: got %0h want f", data_out);
        end
        while (exp_ch != 1) do_read(16'($urandom), $urandom_range(1, 8), den_s, addr_s, vld_s);
        do_read(16'h00F0, $urandom_range(1, 8), den_s, addr_s, vld_s);
        sel = 3'd1;
        #0.5;
        checks++;
        if (data_out !== 4'h0) begin
            errors++; $display("FAIL mask_00f0: got %0h want 0", data_out);
        end
    endtask

    task automatic test_pwm();
        logic den_s, vld_s;
        logic [6:0] addr_s;
        int c, o, n, f1, lows, highs;
        c = exp_ch;
        o = (c + 1) % N_CH;
        // 16'h10F5 must land as 12'h100 once the noise bits are cleared.
        do_read(16'h10F5, $urandom_range(1, 8), den_s, addr_s, vld_s);
        do_read(16'hFFFF, $urandom_range(1, 8), den_s, addr_s, vld_s);
        while (exp_ch != c) do_read(16'($urandom), $urandom_range(1, 8), den_s, addr_s, vld_s);
        n = 0;
        while (pwm_out[c] !== 1'b1 && n < 3 * PERIOD) begin tick(); n++; end
        n = 0;
        while (pwm_out[c] !== 1'b0 && n < 3 * PERIOD) begin tick(); n++; end
        checks++;
        if (n >= 3 * PERIOD) begin
            errors++; $display("FAIL pwm_start: got no assertion in %0d cycles want one", n);
        end
        n = 0;
        while (pwm_out[c] === 1'b0 && n < PERIOD) begin tick(); n++; end
        checks++;
        if (n != 256) begin
            errors++; $display("FAIL pwm_low_len: got %0d want 256", n);
        end
        n = 0;
        while (pwm_out[c] === 1'b1 && n < PERIOD) begin tick(); n++; end
        checks++;
        if (n != PERIOD - 256) begin
            errors++; $display("FAIL pwm_high_len: got %0d want %0d", n, PERIOD - 256);
        end
        f1 = cyc;
        repeat (20) tick();
        do_read(16'h000A, $urandom_range(1, 8), den_s, addr_s, vld_s);
        n = 0;
        while (pwm_out[c] === 1'b0 && n < PERIOD) begin tick(); n++; end
        checks++;
        if (cyc - f1 != 256) begin
            errors++; $display("FAIL pwm_midperiod: got low for %0d want 256", cyc - f1);
        end
        lows = 0;
        highs = 0;
        repeat (2 * PERIOD) begin
            tick();
            if (pwm_out[c] === 1'b0) lows++;
            if (pwm_out[o] === 1'b1) highs++;
        end
        checks++;
        if (lows != 0) begin
            errors++; $display("FAIL pwm_zero_duty: got %0d asserted cycles want 0", lows);
        end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL pwm_full_duty: got %0d deasserted cycles want 0", highs);
        end
    endtask

    task automatic test_overlap();
        int d0 = den_cnt;
        int v0 = vld_cnt;
        logic [15:0] d1, d2;
        logic [6:0] want;
        int ch2;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        drdy_in = 1'b1;
        do_in   = ~d1;
        repeat (2) tick();
        drdy_in = 1'b0;
        checks++;
        if (vld_cnt != v0) begin
            errors++; $display("FAIL ovl_idle_drdy: got vld delta %0d want 0", vld_cnt - v0);
        end
        eoc_in = 1'b1;
        tick();
        want = addr_tbl[exp_ch];
        checks++;
        if (den_out !== 1'b1 || daddr_out !== want) begin
            errors++; $display("FAIL ovl_den: got den=%0b addr=%0h want 1 %0h", den_out, daddr_out, want);
        end
        repeat (3) tick();
        eoc_in  = 1'b0;
        drdy_in = 1'b1;
        do_in   = d1;
        tick();
        drdy_in = 1'b0;
        tick();
        exp_duty[exp_ch] = masked(d1);
        exp_ch = (exp_ch + 1) % N_CH;
        checks++;
        if (den_cnt - d0 != 1 || vld_cnt - v0 != 1) begin
            errors++;
            $display("FAIL ovl_single_den: got den=%0d vld=%0d want 1 1", den_cnt - d0, vld_cnt - v0);
        end
        // eoc and drdy together in IDLE: the drdy data must not be taken.
        ch2 = exp_ch;
        eoc_in  = 1'b1;
        drdy_in = 1'b1;
        do_in   = d2 ^ 16'hF000;
        tick();
        eoc_in  = 1'b0;
        drdy_in = 1'b0;
        repeat (2) tick();
        drdy_in = 1'b1;
        do_in   = d2;
        tick();
        drdy_in = 1'b0;
        tick();
        exp_duty[ch2] = masked(d2);
        exp_ch = (exp_ch + 1) % N_CH;
        sel = 3'(ch2);
        #0.5;
        checks++;
        if (data_out !== exp_duty[ch2][11:8] || vld_cnt - v0 != 2) begin
            errors++;
            $display("FAIL ovl_same_cycle: got data=%0h vld=%0d want %0h 2", data_out,
                     vld_cnt - v0, exp_duty[ch2][11:8]);
        end
    endtask

    task automatic test_timeout();
        int v0 = vld_cnt;
        logic den_s, vld_s;
        logic [6:0] addr_s, want;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        repeat (60) tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_early: got %0b want 0", timeout_err);
        end
        repeat (10) tick();
        checks++;
        if (timeout_err !== 1'b1 || vld_cnt != v0) begin
            errors++;
            $display("FAIL tmo_set: got err=%0b vld=%0d want 1 0", timeout_err, vld_cnt - v0);
        end
        exp_ch = (exp_ch + 1) % N_CH;
        for (int s = 0; s < N_CH; s++) begin
            sel = 3'(s);
            #0.5;
            checks++;
            if (data_out !== exp_duty[s][11:8]) begin
                errors++;
                $display("FAIL tmo_duty_sel%0d: got %0h want %0h", s, data_out, exp_duty[s][11:8]);
            end
        end
        want = addr_tbl[exp_ch];
        do_read(16'($urandom), $urandom_range(1, 8), den_s, addr_s, vld_s);
        checks++;
        if (addr_s !== want || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_next: got addr=%0h err=%0b want %0h 1", addr_s, timeout_err, want);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic den_s, vld_s;
        logic [6:0] addr_s;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (den_out !== 1'b0 || pwm_out !== 4'hF || timeout_err !== 1'b0 || daddr_out !== 7'h03) begin
            errors++;
            $display("FAIL rst_async: got den=%0b pwm=%0h err=%0b addr=%0h want 0 f 0 03",
                     den_out, pwm_out, timeout_err, daddr_out);
        end
        for (int s = 0; s < N_CH; s++) begin
            sel = 3'(s);
            #0.5;
            checks++;
            if (data_out !== 4'h0) begin
                errors++; $display("FAIL rst_duty_sel%0d: got %0h want 0", s, data_out);
            end
        end
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        tick();
        do_read(16'($urandom), 3, den_s, addr_s, vld_s);
        checks++;
        if (addr_s !== 7'h03 || den_s !== 1'b1 || vld_s !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_read: got addr=%0h den=%0b vld=%0b want 03 1 1",
                     addr_s, den_s, vld_s);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_masking();
        test_pwm();
        test_overlap();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
